rally_ball: RTL and testbench

Parametrised ball-and-rally engine for the tennis/squash LED game: moves a one-hot ball across a configurable LED strip, detects player returns within an end-of-court window, speeds up per hit, and scores misses. Supports tennis mode, with two players, and squash mode, where the right end is a wall that reflects automatically. It sits between the debounced player buttons/serve switches and the LED/score display logic, as the generalised successor of the fixed 16-light slow ball.

---
 rtl/rally_ball.sv | 169 ++++++++++++++++
 tb/tb_rally_ball.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rally_ball.sv
// Ball-and-rally engine for the LED tennis/squash game: steps a one-hot ball along
// the strip, takes returns at the end positions, speeds up per hit and scores misses.
//
// state  | meaning
// IDLE   | no ball in play, waiting for a serve
// MOVE_R | ball travelling toward index 0 (right end)
// MOVE_L | ball travelling toward index LIGHTS-1 (left end)
// POINT  | one-cycle scoring pulse, then back to IDLE
module rally_ball #(
    parameter int LIGHTS       = 16,
    parameter int DIV_WIDTH    = 24,
    parameter int BASE_PERIOD  = 12_500_000,
    parameter int SPEEDUP_STEP = 1_000_000,
    parameter int MIN_PERIOD   = 2_500_000,
    parameter int HIT_WIDTH    = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 leftdirection,
    input  logic                 rightdirection,
    input  logic [1:0]           serve,
    input  logic                 mode,
    output logic [LIGHTS-1:0]    light,
    output logic [1:0]           direction,
    output logic [HIT_WIDTH-1:0] hitnum,
    output logic                 point_left,
    output logic                 point_right
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MOVE_R = 2'd1;
    localparam logic [1:0] S_MOVE_L = 2'd2;
    localparam logic [1:0] S_POINT  = 2'd3;

    localparam int PIW = $clog2(LIGHTS);
    localparam int PW  = DIV_WIDTH + HIT_WIDTH;
    localparam logic [PIW-1:0] LAST = PIW'(LIGHTS - 1);

    localparam logic [PW-1:0] BASE_W  = PW'(BASE_PERIOD);
    localparam logic [PW-1:0] SPEED_W = PW'(SPEEDUP_STEP);
    localparam logic [PW-1:0] MIN_W   = PW'(MIN_PERIOD);

    logic [1:0]           state, nxt_state;
    logic [PIW-1:0]       pos, nxt_pos;
    logic [DIV_WIDTH-1:0] timer, nxt_timer;
    logic [HIT_WIDTH-1:0] nxt_hitnum, hit_inc;
    logic                 hit_pending, nxt_pending;
    logic                 left_q, right_q;
    logic                 l_edge, r_edge;
    logic                 nxt_pl, nxt_pr;
    logic [PW-1:0]        prod, period;
    logic                 tick;

    assign l_edge = leftdirection & ~left_q;
    assign r_edge = rightdirection & ~right_q;
    assign hit_inc = (hitnum == '1) ? hitnum : hitnum + HIT_WIDTH'(1);

    // Clamp compare done before subtracting so a large hit count never wraps.
    always_comb begin
        prod = PW'(hitnum) * SPEED_W;
        if (prod >= BASE_W || (BASE_W - prod) < MIN_W) period = MIN_W;
        else                                            period = BASE_W - prod;
    end

    assign tick = (PW'(timer) == period - PW'(1));

    always_comb begin
        nxt_state   = state;
        nxt_pos     = pos;
        nxt_hitnum  = hitnum;
        nxt_pending = hit_pending;
        nxt_timer   = timer + DIV_WIDTH'(1);
        nxt_pl      = 1'b0;
        nxt_pr      = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_timer = '0;
                if (serve == 2'b01 || (serve == 2'b10 && mode)) begin
                    nxt_state   = S_MOVE_R;
                    nxt_pos     = LAST;
                    nxt_hitnum  = '0;
                    nxt_pending = 1'b0;
                end else if (serve == 2'b10) begin
                    nxt_state   = S_MOVE_L;
                    nxt_pos     = '0;
                    nxt_hitnum  = '0;
                    nxt_pending = 1'b0;
                end
            end
            S_MOVE_R: begin
                if (pos == '0 && !mode && r_edge) nxt_pending = 1'b1;
                if (tick) begin
                    nxt_timer   = '0;
                    nxt_pending = 1'b0;
                    if (pos != '0) begin
                        nxt_pos = pos - PIW'(1);
                    end else if (mode) begin
                        nxt_pos   = PIW'(1);
                        nxt_state = S_MOVE_L;
                    end else if (hit_pending || r_edge) begin
                        nxt_pos    = PIW'(1);
                        nxt_state  = S_MOVE_L;
                        nxt_hitnum = hit_inc;
                    end else begin
                        nxt_state = S_POINT;
                        nxt_pl    = 1'b1;
                    end
                end
            end
            S_MOVE_L: begin
                if (pos == LAST && l_edge) nxt_pending = 1'b1;
                if (tick) begin
                    nxt_timer   = '0;
                    nxt_pending = 1'b0;
                    if (pos != LAST) begin
                        nxt_pos = pos + PIW'(1);
                    end else if (hit_pending || l_edge) begin
                        nxt_pos    = LAST - PIW'(1);
                        nxt_state  = S_MOVE_R;
                        nxt_hitnum = hit_inc;
                    end else begin
                        nxt_state = S_POINT;
                        nxt_pr    = 1'b1;
                    end
                end
            end
            default: begin
                nxt_timer = '0;
                nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pos         <= '0;
            timer       <= '0;
            hitnum      <= '0;
            hit_pending <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            light       <= '0;
            direction   <= 2'b00;
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            state       <= nxt_state;
            pos         <= nxt_pos;
            timer       <= nxt_timer;
            hitnum      <= nxt_hitnum;
            hit_pending <= nxt_pending;
            left_q      <= leftdirection;
            right_q     <= rightdirection;
            point_left  <= nxt_pl;
            point_right <= nxt_pr;
            if (nxt_state == S_MOVE_R || nxt_state == S_MOVE_L)
                light <= LIGHTS'(1) << nxt_pos;
            else
                light <= '0;
            case (nxt_state)
                S_MOVE_R: direction <= 2'b01;
                S_MOVE_L: direction <= 2'b10;
                default:  direction <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_rally_ball.sv
// Directed bench for rally_ball with a 4-light strip and a short step period.
module tb_rally_ball;

    logic       clock;
    logic       reset;
    logic       leftdirection;
    logic       rightdirection;
    logic [1:0] serve;
    logic       mode;
    logic [3:0] light;
    logic [1:0] direction;
    logic [1:0] hitnum;
    logic       point_left;
    logic       point_right;

    int total = 0;
    int bad   = 0;

    rally_ball #(
        .LIGHTS(4), .DIV_WIDTH(8), .BASE_PERIOD(4),
        .SPEEDUP_STEP(1), .MIN_PERIOD(2), .HIT_WIDTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .leftdirection(leftdirection), .rightdirection(rightdirection),
        .serve(serve), .mode(mode),
        .light(light), .direction(direction), .hitnum(hitnum),
        .point_left(point_left), .point_right(point_right)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Checks the ball sits at exp for n consecutive samples, leaving the bench
    // on the first sample of the following position.
    task automatic dwell(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {28'd0, light}, {28'd0, exp});
            step(1);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_light"}, {28'd0, light}, 32'd0);
        chk({tag, "_dir"}, {30'd0, direction}, 32'd0);
        chk({tag, "_pl"}, {31'd0, point_left}, 32'd0);
        chk({tag, "_pr"}, {31'd0, point_right}, 32'd0);
    endtask

    task automatic do_serve(input logic [1:0] s);
        serve = s;
        step(1);
        serve = 2'b00;
    endtask

    initial begin
        reset = 1'b0; leftdirection = 1'b0; rightdirection = 1'b0;
        serve = 2'b00; mode = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_hit", {30'd0, hitnum}, 32'd0);
        step(2);
        reset = 1'b1;
        step(2);
        chk_idle("idle");
        do_serve(2'b11);
        step(1);
        chk_idle("serve11");

        // Serve from left, nobody returns.
        do_serve(2'b01);
        chk("s1_dir", {30'd0, direction}, 32'd1);
        chk("s1_hit", {30'd0, hitnum}, 32'd0);
        dwell("s1_p3", 4'b1000, 4);
        dwell("s1_p2", 4'b0100, 4);
        dwell("s1_p1", 4'b0010, 4);
        dwell("s1_p0", 4'b0001, 4);
        chk("s1_pl", {31'd0, point_left}, 32'd1);
        chk("s1_pr", {31'd0, point_right}, 32'd0);
        chk("s1_ptlight", {28'd0, light}, 32'd0);
        chk("s1_ptdir", {30'd0, direction}, 32'd0);
        step(1);
        chk_idle("s1_after");

        // Rally with speed-up and saturation.
        do_serve(2'b01);
        dwell("r_p3", 4'b1000, 4);
        dwell("r_p2", 4'b0100, 4);
        dwell("r_p1", 4'b0010, 4);
        rightdirection = 1'b1;
        dwell("r_p0", 4'b0001, 4);
        rightdirection = 1'b0;
        chk("r_hit1", {30'd0, hitnum}, 32'd1);
        chk("r_dir1", {30'd0, direction}, 32'd2);
        dwell("r1_p1", 4'b0010, 3);
        dwell("r1_p2", 4'b0100, 3);
        leftdirection = 1'b1;
        dwell("r1_p3", 4'b1000, 3);
        leftdirection = 1'b0;
        chk("r_hit2", {30'd0, hitnum}, 32'd2);
        chk("r_dir2", {30'd0, direction}, 32'd1);
        dwell("r2_p2", 4'b0100, 2);
        dwell("r2_p1", 4'b0010, 2);
        // Press lands in the tick cycle itself.
        chk("r2_p0a", {28'd0, light}, 32'h1);
        step(1);
        chk("r2_p0b", {28'd0, light}, 32'h1);
        rightdirection = 1'b1;
        step(1);
        rightdirection = 1'b0;
        chk("r_hit3", {30'd0, hitnum}, 32'd3);
        dwell("r3_p1", 4'b0010, 2);
        dwell("r3_p2", 4'b0100, 2);
        leftdirection = 1'b1;
        dwell("r3_p3", 4'b1000, 2);
        leftdirection = 1'b0;
        chk("r_hitsat", {30'd0, hitnum}, 32'd3);
        dwell("r4_p2", 4'b0100, 2);
        dwell("r4_p1", 4'b0010, 2);
        dwell("r4_p0", 4'b0001, 2);
        chk("r_pl", {31'd0, point_left}, 32'd1);
        chk("r_pr", {31'd0, point_right}, 32'd0);
        step(1);
        chk("r_hithold", {30'd0, hitnum}, 32'd3);
        chk_idle("r_after");

        // Ignored inputs: early/held right, left at the right end, serve mid-rally.
        do_serve(2'b01);
        chk("ig_hitclr", {30'd0, hitnum}, 32'd0);
        serve = 2'b10;
        leftdirection = 1'b1;
        dwell("ig_p3", 4'b1000, 4);
        serve = 2'b00;
        leftdirection = 1'b0;
        rightdirection = 1'b1;
        dwell("ig_p2", 4'b0100, 4);
        dwell("ig_p1", 4'b0010, 4);
        leftdirection = 1'b1;
        dwell("ig_p0", 4'b0001, 4);
        leftdirection = 1'b0;
        rightdirection = 1'b0;
        chk("ig_pl", {31'd0, point_left}, 32'd1);
        chk("ig_hit", {30'd0, hitnum}, 32'd0);
        step(1);
        chk_idle("ig_after");

        // Squash: serve 10 acts as 01, wall bounces, right button ignored.
        mode = 1'b1;
        do_serve(2'b10);
        chk("sq_dir", {30'd0, direction}, 32'd1);
        dwell("sq_p3", 4'b1000, 4);
        dwell("sq_p2", 4'b0100, 4);
        dwell("sq_p1", 4'b0010, 4);
        rightdirection = 1'b1;
        dwell("sq_p0", 4'b0001, 4);
        rightdirection = 1'b0;
        chk("sq_bdir", {30'd0, direction}, 32'd2);
        chk("sq_hit", {30'd0, hitnum}, 32'd0);
        dwell("sq_b1", 4'b0010, 4);
        dwell("sq_b2", 4'b0100, 4);
        dwell("sq_b3", 4'b1000, 4);
        chk("sq_pr", {31'd0, point_right}, 32'd1);
        chk("sq_pl", {31'd0, point_left}, 32'd0);
        step(1);
        chk_idle("sq_after");

        // Async reset just before a missing tick.
        mode = 1'b0;
        do_serve(2'b01);
        dwell("ar_p3", 4'b1000, 4);
        dwell("ar_p2", 4'b0100, 4);
        dwell("ar_p1", 4'b0010, 4);
        dwell("ar_p0", 4'b0001, 3);
        #3;
        reset = 1'b0;
        #1;
        chk_idle("ar_now");
        chk("ar_hit", {30'd0, hitnum}, 32'd0);
        step(2);
        chk_idle("ar_held");
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_idle("ar_rel");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
